// File: rtl/sirv_mrom_icb_arb.sv
// Two-port round-robin ICB arbiter in front of the combinational mask ROM.
// Each accepted read is registered into a one-entry response buffer; writes and bad addresses return err.
module sirv_mrom_icb_arb #(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int DP = 1024
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_icb_cmd_valid,
  output logic          m0_icb_cmd_ready,
  input  logic [AW-1:0] m0_icb_cmd_addr,
  input  logic          m0_icb_cmd_read,
  output logic          m0_icb_rsp_valid,
  input  logic          m0_icb_rsp_ready,
  output logic          m0_icb_rsp_err,
  output logic [DW-1:0] m0_icb_rsp_rdata,

  input  logic          m1_icb_cmd_valid,
  output logic          m1_icb_cmd_ready,
  input  logic [AW-1:0] m1_icb_cmd_addr,
  input  logic          m1_icb_cmd_read,
  output logic          m1_icb_rsp_valid,
  input  logic          m1_icb_rsp_ready,
  output logic          m1_icb_rsp_err,
  output logic [DW-1:0] m1_icb_rsp_rdata,

  output logic [AW-3:0] rom_addr,
  input  logic [DW-1:0] rom_dout
);

  // state | meaning
  // EMPTY | no response pending, any command can be accepted
  // FULL  | response held for owner_q until its rsp handshake
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  // Held at AW bits so DP = 2^(AW-2) is representable and the range check never fires.
  localparam logic [AW-1:0] DP_W = AW'(DP);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          rsp_fire;
  logic          accept_ok;
  logic          grant;
  logic          cmd_fire;
  logic          sel_read;
  logic          new_err;
  logic [AW-1:0] sel_addr;

  always_comb begin
    rsp_fire  = (state_q == FULL) & (owner_q ? m1_icb_rsp_ready : m0_icb_rsp_ready);
    accept_ok = (state_q == EMPTY) | rsp_fire;

    grant = m1_icb_cmd_valid;
    if (m0_icb_cmd_valid & m1_icb_cmd_valid) begin
      grant = ~last_q;
    end

    sel_addr = grant ? m1_icb_cmd_addr : m0_icb_cmd_addr;
    sel_read = grant ? m1_icb_cmd_read : m0_icb_cmd_read;
    cmd_fire = accept_ok & (grant ? m1_icb_cmd_valid : m0_icb_cmd_valid);
    new_err  = ~sel_read
             | (sel_addr[1:0] != 2'b00)
             | ({2'b00, sel_addr[AW-1:2]} >= DP_W);
  end

  assign rom_addr         = sel_addr[AW-1:2];
  assign m0_icb_cmd_ready = accept_ok & ~grant;
  assign m1_icb_cmd_ready = accept_ok & grant;

  assign m0_icb_rsp_valid = (state_q == FULL) & ~owner_q;
  assign m1_icb_rsp_valid = (state_q == FULL) & owner_q;
  assign m0_icb_rsp_err   = err_q;
  assign m1_icb_rsp_err   = err_q;
  assign m0_icb_rsp_rdata = rdata_q;
  assign m1_icb_rsp_rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (cmd_fire) begin
      // Accept wins over retire so a back-to-back command reloads with no gap.
      state_d = FULL;
      owner_d = grant;
      last_d  = grant;
      err_d   = new_err;
      rdata_d = new_err ? '0 : rom_dout;
    end else if (rsp_fire) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
